// File: rtl/rca_result_checker.sv
// Checks a ripple-carry adder: compares observed {cout,sum} against a+b+cin over a run of NUM_VEC vectors.
// Optional macro RCA_CHK_FAIL_LOG_EN enables the first-mismatch record (index, expected, observed).
module rca_result_checker #(
    parameter int WIDTH   = 4,
    parameter int NUM_VEC = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       pass_cnt,
    output logic [7:0]       fail_cnt,
    output logic [7:0]       first_fail_idx,
    output logic [WIDTH:0]   first_fail_exp,
    output logic [WIDTH:0]   first_fail_obs
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(NUM_VEC - 1);
    localparam logic [7:0] CNT_MAX  = 8'd255;

    state_t         state_q, state_d;
    logic [7:0]     idx_q, idx_d;
    logic [7:0]     pass_cnt_q, pass_cnt_d;
    logic [7:0]     fail_cnt_q, fail_cnt_d;
    logic           cmp_vld_q, cmp_vld_d;
    logic           cmp_ok_q, cmp_ok_d;
    logic [WIDTH:0] exp_s;
    logic [WIDTH:0] obs_s;
    logic           accept_s;
    logic           clear_s;

    // Full-width expected sum so the top carry is never truncated
    assign exp_s    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign obs_s    = {cout, sum};
    assign accept_s = in_valid && (state_q == RUN);
    assign clear_s  = start && ((state_q == IDLE) || (state_q == DONE));

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
                else       state_d = IDLE;
            end
            RUN: begin
                if (accept_s && (idx_q == LAST_IDX)) state_d = DRAIN;
                else                                 state_d = RUN;
            end
            DRAIN: state_d = DONE;
            DONE: begin
                if (start) state_d = RUN;
                else       state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Vector index, compare pipeline stage and saturating counters
    always_comb begin
        idx_d      = idx_q;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        cmp_vld_d  = accept_s;
        cmp_ok_d   = (exp_s == obs_s);
        if (clear_s) begin
            idx_d      = 8'd0;
            pass_cnt_d = 8'd0;
            fail_cnt_d = 8'd0;
            cmp_vld_d  = 1'b0;
        end else begin
            if (accept_s) idx_d = idx_q + 8'd1;
            else          idx_d = idx_q;
            if (cmp_vld_q) begin
                if (cmp_ok_q) begin
                    if (pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + 8'd1;
                    else                       pass_cnt_d = pass_cnt_q;
                end else begin
                    if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + 8'd1;
                    else                       fail_cnt_d = fail_cnt_q;
                end
            end else begin
                pass_cnt_d = pass_cnt_q;
            end
        end
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 8'd0;
            pass_cnt_q <= 8'd0;
            fail_cnt_q <= 8'd0;
            cmp_vld_q  <= 1'b0;
            cmp_ok_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            cmp_vld_q  <= cmp_vld_d;
            cmp_ok_q   <= cmp_ok_d;
        end
    end

`ifdef RCA_CHK_FAIL_LOG_EN
    logic [7:0]     cmp_idx_q;
    logic [WIDTH:0] cmp_exp_q;
    logic [WIDTH:0] cmp_obs_q;
    logic           ff_seen_q;
    logic [7:0]     ff_idx_q;
    logic [WIDTH:0] ff_exp_q;
    logic [WIDTH:0] ff_obs_q;

    // Capture only the first mismatch of a run; the seen flag blocks overwrites
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_idx_q <= 8'd0;
            cmp_exp_q <= '0;
            cmp_obs_q <= '0;
            ff_seen_q <= 1'b0;
            ff_idx_q  <= 8'd0;
            ff_exp_q  <= '0;
            ff_obs_q  <= '0;
        end else if (clear_s) begin
            cmp_idx_q <= 8'd0;
            cmp_exp_q <= '0;
            cmp_obs_q <= '0;
            ff_seen_q <= 1'b0;
            ff_idx_q  <= 8'd0;
            ff_exp_q  <= '0;
            ff_obs_q  <= '0;
        end else begin
            cmp_idx_q <= idx_q;
            cmp_exp_q <= exp_s;
            cmp_obs_q <= obs_s;
            if (cmp_vld_q && !cmp_ok_q && !ff_seen_q) begin
                ff_seen_q <= 1'b1;
                ff_idx_q  <= cmp_idx_q;
                ff_exp_q  <= cmp_exp_q;
                ff_obs_q  <= cmp_obs_q;
            end
        end
    end

    assign first_fail_idx = ff_idx_q;
    assign first_fail_exp = ff_exp_q;
    assign first_fail_obs = ff_obs_q;
`else
    assign first_fail_idx = 8'd0;
    assign first_fail_exp = '0;
    assign first_fail_obs = '0;
`endif

    assign in_ready = (state_q == RUN);
    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign done     = (state_q == DONE);
    assign pass     = (state_q == DONE) && (fail_cnt_q == 8'd0);
    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;

endmodule

// File: doc/rca_result_checker.md
RCA_RESULT_CHECKER -- requirements
Module: rca_result_checker

Interface
REQ-001 Parameter WIDTH, default 4: operand width of the adder under check, range 1..16.
REQ-002 Parameter NUM_VEC, default 10: vectors per run, range 1..255.
REQ-003 Port clk, input, 1: sole clock; all state changes on the rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port start, input, 1: begin a run (pulse, one cycle).
REQ-006 Port in_valid, input, 1: vector on a/b/cin/sum/cout is valid.
REQ-007 Port in_ready, output, 1: checker accepts a vector this cycle.
REQ-008 Ports a, b, input, WIDTH each: applied operands.
REQ-009 Port cin, input, 1: applied carry-in.
REQ-010 Port sum, input, WIDTH; port cout, input, 1: observed adder response.
REQ-011 Port busy, output, 1: run in progress.
REQ-012 Port done, output, 1: run complete, results stable.
REQ-013 Port pass, output, 1: run complete with zero mismatches.
REQ-014 Ports pass_cnt, fail_cnt, output, 8 each: matching and mismatching vector counts.
REQ-015 Ports first_fail_idx (8), first_fail_exp (WIDTH+1), first_fail_obs (WIDTH+1), output: first mismatch record.

Function
REQ-016 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE: in_ready=0, busy=0; start -> RUN; clears counters, vector index, and the first-fail record on the same edge.
REQ-018 RUN: in_ready=1, busy=1; accept when in_valid&in_ready; vector index increments per accept.
REQ-019 Expected value = a + b + cin computed at WIDTH+1 bits, no truncation; observed = {cout,sum}.
REQ-020 Compare result registered one cycle after acceptance; pass_cnt or fail_cnt increments on that edge (1-cycle latency).
REQ-021 Counters saturate at 255; no wrap.
REQ-022 Accept of vector NUM_VEC -> DRAIN (in_ready=0); DRAIN lasts exactly one cycle, then -> DONE.
REQ-023 DONE: busy=0, done=1, pass=(fail_cnt==0); counters and record held.
REQ-024 start in DONE -> RUN with clear (back-to-back runs); start in RUN/DRAIN ignored.
REQ-025 in_valid while in_ready=0: ignored, not counted.
REQ-026 First mismatch only: index (0-based), expected, and observed captured; later mismatches do not overwrite.
REQ-027 pass=0 outside DONE.

Reset
REQ-028 rst asserted: state=IDLE immediately; in_ready, busy, done, pass=0; all counters, index, and record=0.
REQ-029 rst mid-run aborts the run; no partial result retained; next run requires start.

Configuration
REQ-030 Macro RCA_CHK_FAIL_LOG_EN defined: first-fail record per REQ-026.
REQ-031 Macro undefined: record logic omitted; first_fail_idx/exp/obs tied 0; counters and pass are unaffected.

Verification (WIDTH=4, NUM_VEC=10 unless stated)
REQ-032 10 correct vectors, e.g. a=3,b=5,cin=1,{cout,sum}=5'b01001 -> done=1, pass=1, pass_cnt=10, fail_cnt=0.
REQ-033 Vector 4 (0-based) a=15,b=1,cin=0 observed 5'b00000 -> fail_cnt=1, pass=0, first_fail_idx=4, first_fail_exp=5'b10000, first_fail_obs=5'b00000 (macro defined; all zero if undefined).
REQ-034 Boundary a=15,b=15,cin=1 observed 5'b11111 -> counted pass (no truncation to 4 bits).
REQ-035 in_valid held high across IDLE and DRAIN -> only 10 accepts; done exactly 2 cycles after 10th accept.
REQ-036 rst pulsed after 5 accepts -> all outputs 0 asynchronously, state IDLE; new start runs full 10 cleanly.
REQ-037 NUM_VEC=255, all mismatching -> fail_cnt=255, no wrap; start in DONE restarts with counters cleared.
